// File: rtl/tx_frame_scheduler.sv
// Two-source, frame-granular transmit scheduler in front of the 64-bit MAC TX stream.
// Optional build macro TX_SCHED_PRIORITY_EN: source 0 always wins contention instead of round-robin.

module tx_frame_scheduler #(
  parameter int DATA_WIDTH = 64,
  parameter int IPG_CYCLES = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [DATA_WIDTH-1:0]     s0_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s0_axis_tkeep,
  input  logic                      s0_axis_tvalid,
  input  logic                      s0_axis_tlast,
  output logic                      s0_axis_tready,
  input  logic [DATA_WIDTH-1:0]     s1_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s1_axis_tkeep,
  input  logic                      s1_axis_tvalid,
  input  logic                      s1_axis_tlast,
  output logic                      s1_axis_tready,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [1:0]                o_grant,
  output logic [CNT_WIDTH-1:0]      o_frames0,
  output logic [CNT_WIDTH-1:0]      o_frames1
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS,
    ST_GAP
  } state_t;

  localparam logic [7:0] IPG_LOAD = (IPG_CYCLES > 0) ? 8'(IPG_CYCLES - 1) : 8'd0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                 state_reg;
  logic [1:0]             grant_reg;
  logic [7:0]             gap_cnt_reg;
  logic [CNT_WIDTH-1:0]   frames0_reg;
  logic [CNT_WIDTH-1:0]   frames1_reg;
  logic                   pick_src;
  logic                   in_pass;
  logic                   beat_fire;
`ifdef TX_SCHED_PRIORITY_EN
`else
  logic                   last_reg;
`endif

  // pick_src is the index of the source that wins arbitration this cycle
  always_comb begin
`ifdef TX_SCHED_PRIORITY_EN
    pick_src = !s0_axis_tvalid;
`else
    if (s0_axis_tvalid && s1_axis_tvalid) begin
      pick_src = !last_reg;
    end else begin
      pick_src = !s0_axis_tvalid;
    end
`endif
  end

  assign in_pass = (state_reg == ST_PASS);

  always_comb begin
    m_axis_tdata   = grant_reg[1] ? s1_axis_tdata : s0_axis_tdata;
    m_axis_tkeep   = grant_reg[1] ? s1_axis_tkeep : s0_axis_tkeep;
    m_axis_tlast   = grant_reg[1] ? s1_axis_tlast : s0_axis_tlast;
    m_axis_tvalid  = in_pass && ((grant_reg[0] && s0_axis_tvalid) ||
                                 (grant_reg[1] && s1_axis_tvalid));
    s0_axis_tready = in_pass && grant_reg[0] && m_axis_tready;
    s1_axis_tready = in_pass && grant_reg[1] && m_axis_tready;
  end

  assign beat_fire = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg   <= ST_IDLE;
      grant_reg   <= 2'b00;
      gap_cnt_reg <= 8'd0;
      frames0_reg <= '0;
      frames1_reg <= '0;
`ifdef TX_SCHED_PRIORITY_EN
`else
      last_reg    <= 1'b1;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (s0_axis_tvalid || s1_axis_tvalid) begin
            grant_reg <= pick_src ? 2'b10 : 2'b01;
`ifdef TX_SCHED_PRIORITY_EN
`else
            last_reg  <= pick_src;
`endif
            state_reg <= ST_PASS;
          end
        end
        ST_PASS: begin
          // grant is held through tvalid bubbles; only a tlast transfer releases it
          if (beat_fire && m_axis_tlast) begin
            if (grant_reg[0]) begin
              frames0_reg <= frames0_reg + CNT_ONE;
            end else begin
              frames1_reg <= frames1_reg + CNT_ONE;
            end
            grant_reg <= 2'b00;
            if (IPG_CYCLES == 0) begin
              state_reg <= ST_IDLE;
            end else begin
              gap_cnt_reg <= IPG_LOAD;
              state_reg   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_reg == 8'd0) begin
            state_reg <= ST_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 8'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          grant_reg <= 2'b00;
        end
      endcase
    end
  end

  assign o_grant   = grant_reg;
  assign o_frames0 = frames0_reg;
  assign o_frames1 = frames1_reg;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Randomized bench for tx_frame_scheduler against a frame-level arbitration model.
// A second instance (CNT_WIDTH=2, IPG_CYCLES=0) covers counter wrap and zero-gap spacing.

module tb_tx_frame_scheduler;

  localparam int IPG = 1;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [63:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic [7:0]  s0_axis_tkeep, s1_axis_tkeep, m_axis_tkeep;
  logic        s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
  logic        s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [1:0]  o_grant;
  logic [15:0] o_frames0, o_frames1;

  logic [63:0] w_s0_tdata, w_s1_tdata, w_m_tdata;
  logic [7:0]  w_s0_tkeep, w_s1_tkeep, w_m_tkeep;
  logic        w_s0_tvalid, w_s0_tlast, w_s0_tready;
  logic        w_s1_tvalid, w_s1_tlast, w_s1_tready;
  logic        w_m_tvalid, w_m_tlast, w_m_tready;
  logic [1:0]  w_grant;
  logic [1:0]  w_frames0, w_frames1;

  tx_frame_scheduler #(.DATA_WIDTH(64), .IPG_CYCLES(IPG), .CNT_WIDTH(16)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tlast(s0_axis_tlast),
    .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tlast(s1_axis_tlast),
    .s1_axis_tready(s1_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .o_grant(o_grant), .o_frames0(o_frames0), .o_frames1(o_frames1)
  );

  tx_frame_scheduler #(.DATA_WIDTH(64), .IPG_CYCLES(0), .CNT_WIDTH(2)) dut_w (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .s0_axis_tdata(w_s0_tdata), .s0_axis_tkeep(w_s0_tkeep),
    .s0_axis_tvalid(w_s0_tvalid), .s0_axis_tlast(w_s0_tlast),
    .s0_axis_tready(w_s0_tready),
    .s1_axis_tdata(w_s1_tdata), .s1_axis_tkeep(w_s1_tkeep),
    .s1_axis_tvalid(w_s1_tvalid), .s1_axis_tlast(w_s1_tlast),
    .s1_axis_tready(w_s1_tready),
    .m_axis_tdata(w_m_tdata), .m_axis_tkeep(w_m_tkeep),
    .m_axis_tvalid(w_m_tvalid), .m_axis_tlast(w_m_tlast),
    .m_axis_tready(w_m_tready),
    .o_grant(w_grant), .o_frames0(w_frames0), .o_frames1(w_frames1)
  );

  beat_t q0[$], q1[$], r0[$], r1[$], exp_q[$];
  int    f0_len[$], f1_len[$], exp_src[$], exp_len[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    ready_mode, cnt0, cnt1, model_last;
  int    cur_src, last_first_cyc, prev_len;
  int    s1_pause_left, s1_pause_at, s1_sent;
  bit    chk_spacing, tgl, prev_stall;
  logic [63:0] prev_data;

  function automatic logic [1:0] onehot(input int s);
    return (s == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic add_frame(input int src, input int len);
    beat_t b;
    logic [7:0] ff;
    ff = 8'hFF;
    for (int i = 0; i < len; i++) begin
      b.d = {$urandom, $urandom};
      b.l = (i == len - 1);
      b.k = b.l ? (ff >> $urandom_range(0, 7)) : ff;
      if (src == 0) begin q0.push_back(b); r0.push_back(b); end
      else begin q1.push_back(b); r1.push_back(b); end
    end
    if (src == 0) f0_len.push_back(len);
    else f1_len.push_back(len);
  endtask

  // Frame-level arbitration: whole frames, winner chosen by the source-level rule.
  task automatic build_expected();
    int pick, len;
    while (f0_len.size() > 0 || f1_len.size() > 0) begin
      if (f0_len.size() > 0 && f1_len.size() > 0) begin
`ifdef TX_SCHED_PRIORITY_EN
        pick = 0;
`else
        pick = (model_last == 1) ? 0 : 1;
`endif
      end else begin
        pick = (f0_len.size() > 0) ? 0 : 1;
      end
      len = (pick == 0) ? f0_len.pop_front() : f1_len.pop_front();
      for (int i = 0; i < len; i++) begin
        exp_q.push_back((pick == 0) ? r0.pop_front() : r1.pop_front());
      end
      exp_src.push_back(pick);
      exp_len.push_back(len);
      model_last = pick;
    end
  endtask

  task automatic clear_model();
    q0.delete(); q1.delete(); r0.delete(); r1.delete(); exp_q.delete();
    f0_len.delete(); f1_len.delete(); exp_src.delete(); exp_len.delete();
    cnt0 = 0; cnt1 = 0; model_last = 1; cur_src = -1;
    last_first_cyc = -1; prev_len = 0; prev_stall = 0; tgl = 0;
    s1_pause_left = 0; s1_pause_at = 0; s1_sent = 0;
    s0_axis_tvalid = 0; s0_axis_tlast = 0; s0_axis_tdata = '0; s0_axis_tkeep = '0;
    s1_axis_tvalid = 0; s1_axis_tlast = 0; s1_axis_tdata = '0; s1_axis_tkeep = '0;
    m_axis_tready = 0;
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    clear_model();
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  task automatic step();
    beat_t b, t;
    bit end_frame;
    end_frame = 0;
    if (q0.size() > 0) begin
      {s0_axis_tdata, s0_axis_tkeep, s0_axis_tlast} = q0[0];
      s0_axis_tvalid = 1;
    end else begin
      s0_axis_tvalid = 0; s0_axis_tlast = 0; s0_axis_tdata = {$urandom, $urandom};
    end
    if (s1_pause_left > 0) begin
      s1_axis_tvalid = 0; s1_pause_left--; s1_axis_tdata = {$urandom, $urandom};
    end else if (q1.size() > 0) begin
      {s1_axis_tdata, s1_axis_tkeep, s1_axis_tlast} = q1[0];
      s1_axis_tvalid = 1;
    end else begin
      s1_axis_tvalid = 0; s1_axis_tlast = 0; s1_axis_tdata = {$urandom, $urandom};
    end
    case (ready_mode)
      0: m_axis_tready = 1;
      1: begin tgl = !tgl; m_axis_tready = tgl; end
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
    #1;
    cyc++;
    if (prev_stall) begin
      checks++;
      if (m_axis_tdata !== prev_data) begin
        errors++; $display("FAIL hold_stable: tdata=%h required %h", m_axis_tdata, prev_data);
      end
    end
    if (m_axis_tvalid && m_axis_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL unexpected_beat: tdata=%h required no transfer", m_axis_tdata);
      end else begin
        if (cur_src < 0) begin
          cur_src = exp_src[0];
          if (chk_spacing && last_first_cyc >= 0) begin
            checks++;
            if (cyc - last_first_cyc != prev_len + IPG + 1) begin
              errors++;
              $display("FAIL frame_spacing: got %0d cycles required %0d",
                       cyc - last_first_cyc, prev_len + IPG + 1);
            end
          end
          last_first_cyc = cyc;
          prev_len = exp_len[0];
        end
        b = exp_q.pop_front();
        end_frame = b.l;
        if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== b) begin
          errors++;
          $display("FAIL beat_data: got %h/%h/%b required %h/%h/%b",
                   m_axis_tdata, m_axis_tkeep, m_axis_tlast, b.d, b.k, b.l);
        end
      end
    end
    if (cur_src >= 0) begin
      checks++;
      if (o_grant !== onehot(cur_src) ||
          s0_axis_tready !== ((cur_src == 0) ? m_axis_tready : 1'b0) ||
          s1_axis_tready !== ((cur_src == 1) ? m_axis_tready : 1'b0) ||
          m_axis_tvalid !== ((cur_src == 0) ? s0_axis_tvalid : s1_axis_tvalid)) begin
        errors++;
        $display("FAIL owner_path: grant=%b rdy=%b%b vld=%b required owner=%0d mready=%b",
                 o_grant, s1_axis_tready, s0_axis_tready, m_axis_tvalid, cur_src, m_axis_tready);
      end
    end else if (exp_src.size() == 0) begin
      checks++;
      if (o_grant !== 2'b00 || s0_axis_tready !== 1'b0 || s1_axis_tready !== 1'b0 ||
          m_axis_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs: grant=%b rdy=%b%b vld=%b required all 0",
                 o_grant, s1_axis_tready, s0_axis_tready, m_axis_tvalid);
      end
    end
    if (end_frame && cur_src >= 0) begin
      if (cur_src == 0) cnt0++;
      else cnt1++;
      void'(exp_src.pop_front());
      void'(exp_len.pop_front());
      cur_src = -1;
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    if (s0_axis_tvalid && s0_axis_tready && q0.size() > 0) t = q0.pop_front();
    if (s1_axis_tvalid && s1_axis_tready && q1.size() > 0) begin
      t = q1.pop_front();
      s1_sent = t.l ? 0 : s1_sent + 1;
      if (s1_pause_at > 0 && s1_sent == s1_pause_at) begin
        s1_pause_left = 3; s1_pause_at = 0;
      end
    end
    @(negedge i_clk);
  endtask

  task automatic run(input string name, input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step(); n++;
    end
    checks++;
    if (q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0) begin
      errors++; $display("FAIL %s_timeout: %0d beats left required 0", name, exp_q.size());
    end
    repeat (3) step();
    checks++;
    if (o_frames0 !== 16'(cnt0) || o_frames1 !== 16'(cnt1)) begin
      errors++;
      $display("FAIL %s_counters: frames0=%0d frames1=%0d required %0d %0d",
               name, o_frames0, o_frames1, cnt0, cnt1);
    end
    $display("%s: checks=%0d errors=%0d frames0=%0d frames1=%0d",
             name, checks, errors, o_frames0, o_frames1);
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    #1;
    checks++;
    if (o_grant !== 2'b00 || m_axis_tvalid !== 1'b0 || s0_axis_tready !== 1'b0 ||
        s1_axis_tready !== 1'b0 || o_frames0 !== 16'd0 || o_frames1 !== 16'd0 ||
        w_grant !== 2'b00 || w_frames0 !== 2'd0 || w_m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: grant=%b vld=%b rdy=%b%b f0=%0d f1=%0d required zeros",
               o_grant, m_axis_tvalid, s1_axis_tready, s0_axis_tready, o_frames0, o_frames1);
    end
    do_reset();
  endtask

  task automatic test_single_source();
    do_reset();
    ready_mode = 0; chk_spacing = 1;
    for (int i = 0; i < 3; i++) add_frame(0, 4);
    build_expected();
    run("single_source", 200);
  endtask

  task automatic test_contention();
    do_reset();
    ready_mode = 0; chk_spacing = 1;
    for (int i = 0; i < 4; i++) begin add_frame(0, 2); add_frame(1, 2); end
    build_expected();
    run("contention", 300);
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_mode = 1; chk_spacing = 0;
    add_frame(0, 5); add_frame(1, 3);
    build_expected();
    run("backpressure", 200);
  endtask

  task automatic test_valid_gap();
    int n;
    do_reset();
    ready_mode = 0; chk_spacing = 0;
    add_frame(1, 6);
    s1_pause_at = 2;
    build_expected();
    n = 0;
    while (cur_src != 1 && n < 20) begin step(); n++; end
    add_frame(0, 3);
    build_expected();
    run("valid_gap", 200);
  endtask

  task automatic test_reset_mid_frame();
    int n;
    do_reset();
    ready_mode = 0; chk_spacing = 0;
    add_frame(0, 3); add_frame(1, 5);
    build_expected();
    n = 0;
    while (!(cur_src == 1 && exp_q.size() == 4) && n < 50) begin step(); n++; end
    checks++;
    if (o_frames0 !== 16'd1) begin
      errors++; $display("FAIL pre_reset_count: frames0=%0d required 1", o_frames0);
    end
    i_reset_n = 1'b0;
    #1;
    checks++;
    if (o_grant !== 2'b00 || m_axis_tvalid !== 1'b0 || s0_axis_tready !== 1'b0 ||
        s1_axis_tready !== 1'b0 || o_frames0 !== 16'd0 || o_frames1 !== 16'd0) begin
      errors++;
      $display("FAIL midframe_reset: grant=%b vld=%b f0=%0d f1=%0d required zeros",
               o_grant, m_axis_tvalid, o_frames0, o_frames1);
    end
    clear_model();
    @(negedge i_clk);
    i_reset_n = 1'b1;
    add_frame(1, 2); add_frame(0, 2);
    build_expected();
    run("reset_mid_frame", 100);
  endtask

  task automatic test_random();
    do_reset();
    ready_mode = 2; chk_spacing = 0;
    for (int i = 0; i < int'($urandom_range(2, 5)); i++) add_frame(0, $urandom_range(1, 6));
    for (int i = 0; i < int'($urandom_range(2, 5)); i++) add_frame(1, $urandom_range(1, 6));
    build_expected();
    run("random", 1500);
  endtask

  task automatic test_wrap_zero_ipg();
    int sent, n, last_n;
    logic [63:0] cur_d;
    do_reset();
    w_m_tready = 1; sent = 0; n = 0; last_n = -1;
    cur_d = {$urandom, $urandom};
    while (sent < 5 && n < 60) begin
      w_s0_tvalid = 1; w_s0_tlast = 1; w_s0_tkeep = 8'hFF; w_s0_tdata = cur_d;
      #1;
      if (w_m_tvalid && w_m_tready) begin
        checks++;
        if (w_m_tdata !== cur_d || w_m_tlast !== 1'b1) begin
          errors++; $display("FAIL wrap_beat: tdata=%h required %h", w_m_tdata, cur_d);
        end
        if (last_n >= 0) begin
          checks++;
          if (n - last_n != 2) begin
            errors++; $display("FAIL zero_ipg_spacing: got %0d cycles required 2", n - last_n);
          end
        end
        last_n = n; sent++;
        cur_d = {$urandom, $urandom};
      end
      @(negedge i_clk);
      n++;
    end
    w_s0_tvalid = 0; w_s0_tlast = 0;
    repeat (3) @(negedge i_clk);
    checks++;
    if (sent != 5 || w_frames0 !== 2'd1 || w_frames1 !== 2'd0) begin
      errors++;
      $display("FAIL wrap_counter: sent=%0d frames0=%0d frames1=%0d required 5 1 0",
               sent, w_frames0, w_frames1);
    end
    $display("wrap_zero_ipg: frames sent=%0d frames0=%0d", sent, w_frames0);
  endtask

  initial begin
    clear_model();
    ready_mode = 0; chk_spacing = 0;
    w_s0_tdata = '0; w_s0_tkeep = '0; w_s0_tvalid = 0; w_s0_tlast = 0;
    w_s1_tdata = '0; w_s1_tkeep = '0; w_s1_tvalid = 0; w_s1_tlast = 0;
    w_m_tready = 0;
    @(negedge i_clk);
    test_reset();
    test_single_source();
    test_contention();
    test_backpressure();
    test_valid_gap();
    test_reset_mid_frame();
    test_random();
    test_wrap_zero_ipg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_frame_scheduler.md
# tx_frame_scheduler

Two-source, frame-level transmit scheduler feeding the single 64-bit MAC TX AXI-stream port. It sits between two frame producers (for example, the host path and a loopback/test generator) and the MAC, which performs preamble, SFD and terminate insertion for the XGMII and 64b/66b encoder. It grants the MAC to one source for a whole frame, with round-robin fairness. After each frame it enforces a programmable number of idle cycles before the next grant.

## Interface
Parameters:
- `DATA_WIDTH`, 64, stream data width; keep width is `DATA_WIDTH/8`.
- `IPG_CYCLES`, 1, idle cycles inserted after each frame's last beat (0–255).
- `CNT_WIDTH`, 16, width of the per-source frame counters.

Ports:
- `i_clk`  in  1  transmit clock; all logic is on the rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `s0_axis_tdata`  in  DATA_WIDTH  source 0 data.
- `s0_axis_tkeep`  in  DATA_WIDTH/8  source 0 byte enables.
- `s0_axis_tvalid`  in  1  source 0 valid.
- `s0_axis_tlast`  in  1  source 0 end of frame.
- `s0_axis_tready`  out  1  source 0 ready.
- `s1_axis_*`  same five signals as s0, for source 1.
- `m_axis_tdata`  out  DATA_WIDTH  data to the MAC.
- `m_axis_tkeep`  out  DATA_WIDTH/8  byte enables to the MAC.
- `m_axis_tvalid`  out  1  valid to the MAC.
- `m_axis_tlast`  out  1  end of frame to the MAC.
- `m_axis_tready`  in  1  MAC ready.
- `o_grant`  out  2  one-hot current owner; `2'b00` when no source owns the MAC.
- `o_frames0`, `o_frames1`  out  CNT_WIDTH  completed-frame counters per source; wrap at 2^CNT_WIDTH.

## Operation
The scheduler has three states:
- **IDLE**: no source is granted, and `m_axis_tvalid`, `s0_axis_tready` and `s1_axis_tready` are all 0. If any `sN_axis_tvalid` is 1, the arbiter picks a winner, registers it into `o_grant`, and the state moves to PASS.
- **PASS**: the granted source is combinationally muxed to `m_*`.
  - `sN_axis_tready = m_axis_tready` for the owner; the other source's tready is 0.
  - A beat transfers when `m_axis_tvalid && m_axis_tready`.
  - When a transferring beat has tlast = 1: the owner's frame counter increments, `o_grant` clears to `2'b00`, and the state goes to GAP (or to IDLE if `IPG_CYCLES==0`).
- **GAP**: a down-counter is loaded with `IPG_CYCLES-1`. All readies and `m_axis_tvalid` are 0. The state returns to IDLE when the counter reaches 0.

Arbitration:
- A `last` pointer records the most recent winner; its reset value is 1, so source 0 wins the first contention.
- With a single requester, that requester wins.
- With both requesting, the source not equal to `last` wins, and `last` is updated on each grant.

Boundary rules:
- A source deasserting tvalid mid-frame keeps the grant; the scheduler does not time out.
- A 1-beat frame (tvalid and tlast on the same beat) is legal.
- The loser's tvalid may remain high indefinitely. It is granted after the current frame and gap.
- Asserting reset mid-frame returns the block to IDLE immediately. This truncates the frame; the MAC must discard the partial frame.

## Timing
- Reset values: state = IDLE, `o_grant = 0`, `last = 1`, counters = 0, `m_axis_tvalid = 0`, all `sN_axis_tready = 0`.
- Latency: a request seen in IDLE at edge k is granted at edge k+1. The first beat is presented on `m_*` in the cycle after edge k+1 (1 cycle of arbitration latency). Data has no pipeline delay while in PASS.
- Frame spacing, from the tlast transfer edge to the next possible first beat: `IPG_CYCLES + 1` cycles (the gap cycles plus one IDLE arbitration cycle).
- The counter increment and the `o_grant` clear take effect on the same edge as the tlast transfer.

## Configuration
- **`TX_SCHED_PRIORITY_EN`**
  - Defined: fixed priority. Source 0 always wins contention, and the `last` pointer is unused.
  - Undefined (default): round-robin as described under Operation.
  - All other behaviour is identical in both builds.

## Test plan
- **Single source**: s0 sends 3 frames of 4 beats with `m_axis_tready = 1` and `IPG_CYCLES = 1`. The frames must appear unchanged on `m_*`, with first beats spaced exactly 6 cycles apart. `o_frames0` must read 3 and `o_frames1` must read 0.
- **Contention**: s0 and s1 both hold valid continuously, each sending 2-beat frames. Grants must alternate 0, 1, 0, 1, …; with `TX_SCHED_PRIORITY_EN` defined, only s0 is granted.
- **Backpressure**: toggle `m_axis_tready` on alternate cycles during a 5-beat frame. Each beat must be held stable until accepted, and the owner's tready must mirror `m_axis_tready`.
- **Mid-frame valid gap**: s1 drops tvalid for 3 cycles mid-frame while s0 is requesting. `o_grant` must stay `2'b10` until s1's tlast is transferred.
- **Reset mid-frame**: assert `i_reset_n = 0` on beat 2 of a frame. On the next cycle, outputs must show their reset values and the counters must read 0. After reset release, the first grant goes to s0.
- **Wrap and zero IPG**: with `CNT_WIDTH = 2` and `IPG_CYCLES = 0`, send 5 one-beat frames on s0. `o_frames0` must read 1 and the spacing must be 1 cycle.
